// File: rtl/sobel_stream_filter.sv
// sobel_stream_filter: streaming 3x3 Sobel edge detector on raster RGB888 pixels.
// Define SOBEL_MAG_OUT_EN to add the registered magnitude output mag_out.
module sobel_stream_filter #(
    parameter int          PIC_X_START = 200,
    parameter int          PIC_Y_START = 100,
    parameter int          PIC_WIDTH   = 200,
    parameter int          PIC_HEIGHT  = 200,
    parameter int          MAX_WIDTH   = 1024,
    parameter logic [23:0] EDGE_COLOR  = 24'h000000,
    parameter logic [23:0] BG_COLOR    = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    input  logic [23:0] rgb_data,
    input  logic        mode,
    input  logic [20:0] threshold,
    output logic        out_valid,
    output logic [10:0] out_x,
    output logic [10:0] out_y,
    output logic        edge_flag,
    output logic [23:0] k_sobel_out
`ifdef SOBEL_MAG_OUT_EN
    ,
    output logic [20:0] mag_out
`endif
);

    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t        state;
    logic          parity;
    logic [10:0]   col;
    logic [10:0]   row;
    logic          accept;
    logic          at_origin;
    logic          proc;
    logic          last_col;
    logic          cur_par;
    logic [AW-1:0] addr;
    logic [11:0]   gray_sum;
    logic [7:0]    gray;
    logic [7:0]    top;
    logic [7:0]    mid;

    logic [7:0]    line_a [MAX_WIDTH];
    logic [7:0]    line_b [MAX_WIDTH];

    logic          v1, m1, b1;
    logic [10:0]   x1, y1;
    logic [20:0]   t1;
    logic [23:0]   c0, c1, c2;

    logic [10:0]   gx_p, gx_n, gy_p, gy_n;
    logic          v2, m2, b2;
    logic [10:0]   x2, y2;
    logic [20:0]   t2;
    logic signed [10:0] gx2, gy2;

    logic [9:0]    ax, ay;
    logic [20:0]   mag;
    logic          hit;

    assign col       = pixel_x - 11'(PIC_X_START);
    assign row       = pixel_y - 11'(PIC_Y_START);
    assign accept    = pix_valid
                     && (pixel_x >= 11'(PIC_X_START)) && (col < 11'(PIC_WIDTH))
                     && (pixel_y >= 11'(PIC_Y_START)) && (row < 11'(PIC_HEIGHT));
    assign at_origin = accept && (col == 11'd0) && (row == 11'd0);
    assign proc      = accept && ((state != IDLE) || at_origin);
    assign last_col  = (col == 11'(PIC_WIDTH - 1));
    assign cur_par   = at_origin ? 1'b0 : parity;
    assign addr      = col[AW-1:0];

    assign gray_sum = 12'd5 * 12'(rgb_data[23:16])
                    + 12'd9 * 12'(rgb_data[15:8])
                    + 12'd2 * 12'(rgb_data[7:0]);
    assign gray     = 8'(gray_sum >> 4);

    // Row-2 lives in the RAM the current row is about to overwrite.
    assign top = cur_par ? line_b[addr] : line_a[addr];
    assign mid = cur_par ? line_a[addr] : line_b[addr];

    // Frame tracking and line-buffer ping-pong selection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            parity <= 1'b0;
        end else if (proc) begin
            parity <= last_col ? ~cur_par : cur_par;
            if (at_origin) begin
                state <= FILL;
            end else begin
                case (state)
                    FILL: if (last_col && row == 11'd1) state <= RUN;
                    RUN:  if (last_col && row == 11'(PIC_HEIGHT - 1)) state <= IDLE;
                    default: state <= state;
                endcase
            end
        end
    end

    // Line RAM write; reads above are combinational so they see the old word.
    always_ff @(posedge clk) begin
        if (proc) begin
            if (cur_par) line_b[addr] <= gray;
            else         line_a[addr] <= gray;
        end
    end

    // S1: shift the new column into the 3x3 window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0; m1 <= 1'b0; b1 <= 1'b0;
            x1 <= '0;   y1 <= '0;   t1 <= '0;
            c0 <= '0;   c1 <= '0;   c2 <= '0;
        end else begin
            v1 <= proc;
            if (proc) begin
                x1 <= pixel_x - 11'd1;
                y1 <= pixel_y - 11'd1;
                m1 <= mode;
                t1 <= threshold;
                b1 <= (row < 11'd2) || (col < 11'd2);
                c0 <= (col == 11'd0) ? 24'd0 : c1;
                c1 <= (col == 11'd0) ? 24'd0 : c2;
                c2 <= {top, mid, gray};
            end
        end
    end

    // Column c is packed {row-2,row-1,row}; c0 is the oldest column.
    always_comb begin
        gx_p = 11'(c2[23:16]) + {2'b0, c2[15:8], 1'b0} + 11'(c2[7:0]);
        gx_n = 11'(c0[23:16]) + {2'b0, c0[15:8], 1'b0} + 11'(c0[7:0]);
        gy_p = 11'(c0[7:0])   + {2'b0, c1[7:0], 1'b0}   + 11'(c2[7:0]);
        gy_n = 11'(c0[23:16]) + {2'b0, c1[23:16], 1'b0} + 11'(c2[23:16]);
    end

    // S2: gradients.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0; m2 <= 1'b0; b2 <= 1'b0;
            x2 <= '0;   y2 <= '0;   t2 <= '0;
            gx2 <= '0;  gy2 <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                x2  <= x1;
                y2  <= y1;
                m2  <= m1;
                t2  <= t1;
                b2  <= b1;
                gx2 <= signed'(gx_p - gx_n);
                gy2 <= signed'(gy_p - gy_n);
            end
        end
    end

    always_comb begin
        ax  = gx2[10] ? 10'(-gx2) : 10'(gx2);
        ay  = gy2[10] ? 10'(-gy2) : 10'(gy2);
        mag = m2 ? (21'(ax) * 21'(ax) + 21'(ay) * 21'(ay))
                 : (21'(ax) + 21'(ay));
        hit = !b2 && (mag > t2);
    end

    // S3: magnitude compare and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_x       <= '0;
            out_y       <= '0;
            edge_flag   <= 1'b0;
            k_sobel_out <= BG_COLOR;
`ifdef SOBEL_MAG_OUT_EN
            mag_out     <= '0;
`endif
        end else begin
            out_valid <= v2;
            if (v2) begin
                out_x       <= x2;
                out_y       <= y2;
                edge_flag   <= hit;
                k_sobel_out <= hit ? EDGE_COLOR : BG_COLOR;
`ifdef SOBEL_MAG_OUT_EN
                mag_out     <= b2 ? 21'd0 : mag;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// tb_sobel_stream_filter: randomized frames against a per-pixel Sobel reference.
// Optional mag_out checking when SOBEL_MAG_OUT_EN is defined.
module tb_sobel_stream_filter;

    localparam int XS = 200;
    localparam int YS = 100;
    localparam int W  = 16;
    localparam int H  = 12;
    localparam int N  = (H + 2) * (W + 4);
    localparam logic [23:0] BG   = 24'hFFFFFF;
    localparam logic [23:0] EDGE = 24'h000000;

    typedef struct packed {
        logic [31:0] cyc;
        logic [10:0] x;
        logic [10:0] y;
        logic        e;
        logic [23:0] k;
        logic [20:0] mag;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic [10:0] pixel_x = '0;
    logic [10:0] pixel_y = '0;
    logic [23:0] rgb_data = '0;
    logic        mode = 1'b0;
    logic [20:0] threshold = '0;
    logic        out_valid;
    logic [10:0] out_x;
    logic [10:0] out_y;
    logic        edge_flag;
    logic [23:0] k_sobel_out;
`ifdef SOBEL_MAG_OUT_EN
    logic [20:0] mag_out;
`endif

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    rec_t obs[$];
    rec_t exp_q[$];
    rec_t mon_r;
    bit   active = 1'b0;
    int   img [H][W];

    sobel_stream_filter #(
        .PIC_X_START(XS),
        .PIC_Y_START(YS),
        .PIC_WIDTH  (W),
        .PIC_HEIGHT (H),
        .MAX_WIDTH  (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .rgb_data   (rgb_data),
        .mode       (mode),
        .threshold  (threshold),
        .out_valid  (out_valid),
        .out_x      (out_x),
        .out_y      (out_y),
        .edge_flag  (edge_flag),
        .k_sobel_out(k_sobel_out)
`ifdef SOBEL_MAG_OUT_EN
        ,
        .mag_out    (mag_out)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            mon_r.cyc = 32'(cyc);
            mon_r.x   = out_x;
            mon_r.y   = out_y;
            mon_r.e   = edge_flag;
            mon_r.k   = k_sobel_out;
`ifdef SOBEL_MAG_OUT_EN
            mon_r.mag = mag_out;
`else
            mon_r.mag = '0;
`endif
            obs.push_back(mon_r);
        end
    end

    function automatic int idx(input int r, input int c);
        return (r + 1) * (W + 4) + c + 2;
    endfunction

    function automatic logic [23:0] pat(input int kind, input int c, input int r);
        case (kind)
            0:       return 24'h808080;
            1:       return (c >= W / 2) ? 24'hFFFFFF : 24'h000000;
            2:       return (r >= H / 2) ? 24'hFFFFFF : 24'h000000;
            default: return 24'($urandom);
        endcase
    endfunction

    // Reference: frame image plus direct 3x3 Sobel at the window centre.
    task automatic model_px(input logic [10:0] x, input logic [10:0] y,
                            input logic [23:0] rgb, input logic m,
                            input logic [20:0] t, input int due);
        int   col, row, g, gx, gy, mg, wr;
        bit   org;
        rec_t e;
        col = int'(x) - XS;
        row = int'(y) - YS;
        if (col < 0 || col >= W || row < 0 || row >= H) return;
        org = (col == 0 && row == 0);
        if (!active && !org) return;
        if (org) active = 1'b1;
        g = (5 * int'(rgb[23:16]) + 9 * int'(rgb[15:8]) + 2 * int'(rgb[7:0])) / 16;
        img[row][col] = g;
        e.cyc = 32'(due);
        e.x   = x - 11'd1;
        e.y   = y - 11'd1;
        e.e   = 1'b0;
        e.k   = BG;
        e.mag = '0;
        if (row >= 2 && col >= 2) begin
            gx = 0;
            gy = 0;
            for (int r = 0; r < 3; r++) begin
                wr = (r == 1) ? 2 : 1;
                gx += wr * (img[row-2+r][col] - img[row-2+r][col-2]);
                gy += wr * (img[row][col-2+r] - img[row-2][col-2+r]);
            end
            if (m) mg = gx * gx + gy * gy;
            else   mg = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            e.e = (mg > int'(t));
            e.k = e.e ? EDGE : BG;
`ifdef SOBEL_MAG_OUT_EN
            e.mag = 21'(mg);
`endif
        end
        if (col == W - 1 && row == H - 1) active = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [10:0] x, input logic [10:0] y,
                         input logic [23:0] rgb, input logic m, input logic [20:0] t);
        @(negedge clk);
        pix_valid = v;
        pixel_x   = x;
        pixel_y   = y;
        rgb_data  = rgb;
        mode      = m;
        threshold = t;
        if (v) model_px(x, y, rgb, m, t, cyc + 3);
    endtask

    task automatic flush();
        repeat (6) drive(1'b0, 11'(XS + $urandom_range(0, 2)), 11'(YS), 24'($urandom), 1'b0, '0);
    endtask

    // Raster scan with blanking margins; m==2 randomizes mode/threshold per pixel.
    task automatic run_frame(input int kind, input int m, input int t, input int gap,
                             input int lo, input int hi);
        int n;
        n = 0;
        for (int ry = -1; ry <= H; ry++) begin
            for (int rx = -2; rx <= W + 1; rx++) begin
                if (n >= lo && n <= hi) begin
                    int mm, tt;
                    while ($urandom_range(0, 99) < gap)
                        drive(1'b0, 11'(XS + $urandom_range(0, 2)), 11'(YS + $urandom_range(0, 2)),
                              24'($urandom), 1'($urandom), 21'($urandom));
                    mm = (m == 2) ? int'($urandom_range(0, 1)) : m;
                    tt = (m == 2) ? (mm != 0 ? int'($urandom_range(0, 300000))
                                             : int'($urandom_range(0, 1200))) : t;
                    drive(1'b1, 11'(XS + rx), 11'(YS + ry), pat(kind, rx, ry), 1'(mm), 21'(tt));
                end
                n++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        checks++;
        if (edge_flag !== 1'b0) begin errors++; $display("FAIL reset edge_flag: got %b want 0", edge_flag); end
        checks++;
        if (out_x !== 11'd0) begin errors++; $display("FAIL reset out_x: got %0d want 0", out_x); end
        checks++;
        if (out_y !== 11'd0) begin errors++; $display("FAIL reset out_y: got %0d want 0", out_y); end
        checks++;
        if (k_sobel_out !== BG) begin errors++; $display("FAIL reset k_sobel_out: got %h want %h", k_sobel_out, BG); end
`ifdef SOBEL_MAG_OUT_EN
        checks++;
        if (mag_out !== 21'd0) begin errors++; $display("FAIL reset mag_out: got %0d want 0", mag_out); end
`endif
        #2 rst = 1'b0;
    endtask

    task automatic test_flat();
        int ne, nk;
        obs.delete(); exp_q.delete();
        run_frame(0, 0, 0, 0, 0, N - 1);
        flush();
        checks++;
        if (obs.size() != exp_q.size()) begin errors++; $display("FAIL flat count: got %0d want %0d", obs.size(), exp_q.size()); end
        foreach (obs[i]) begin
            if (i >= exp_q.size()) break;
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL flat out%0d: got cyc=%0d x=%0d y=%0d e=%0b k=%h mag=%0d want cyc=%0d x=%0d y=%0d e=%0b k=%h mag=%0d",
                    i, obs[i].cyc, obs[i].x, obs[i].y, obs[i].e, obs[i].k, obs[i].mag,
                    exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].e, exp_q[i].k, exp_q[i].mag);
                break;
            end
        end
        checks++;
        if (obs.size() != W * H) begin errors++; $display("FAIL flat total: got %0d want %0d", obs.size(), W * H); end
        ne = 0; nk = 0;
        foreach (obs[i]) begin
            if (obs[i].e) ne++;
            if (obs[i].k !== BG) nk++;
        end
        checks++;
        if (ne != 0 || nk != 0) begin errors++; $display("FAIL flat edges: got %0d/%0d want 0/0", ne, nk); end
    endtask

    task automatic test_vstep();
        int thr [3]  = '{500, 15625, 1040400};
        int md [3]   = '{0, 1, 1};
        int want [3] = '{2 * (H - 2), 2 * (H - 2), 0};
        for (int k = 0; k < 3; k++) begin
            int ne, nx;
            obs.delete(); exp_q.delete();
            run_frame(1, md[k], thr[k], 0, 0, N - 1);
            flush();
            checks++;
            if (obs.size() != exp_q.size()) begin errors++; $display("FAIL vstep%0d count: got %0d want %0d", k, obs.size(), exp_q.size()); end
            foreach (obs[i]) begin
                if (i >= exp_q.size()) break;
                checks++;
                if (obs[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL vstep%0d out%0d: got cyc=%0d x=%0d y=%0d e=%0b k=%h mag=%0d want cyc=%0d x=%0d y=%0d e=%0b k=%h mag=%0d",
                        k, i, obs[i].cyc, obs[i].x, obs[i].y, obs[i].e, obs[i].k, obs[i].mag,
                        exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].e, exp_q[i].k, exp_q[i].mag);
                    break;
                end
            end
            ne = 0; nx = 0;
            foreach (obs[i]) begin
                if (obs[i].e) ne++;
                if (obs[i].e && obs[i].x != 11'(XS + W / 2 - 1) && obs[i].x != 11'(XS + W / 2)) nx++;
            end
            checks++;
            if (ne != want[k] || nx != 0) begin errors++; $display("FAIL vstep%0d edges: got %0d (%0d misplaced) want %0d", k, ne, nx, want[k]); end
        end
    endtask

    task automatic test_hstep();
        int na, nb, no;
        obs.delete(); exp_q.delete();
        run_frame(2, 0, 500, 0, 0, N - 1);
        flush();
        checks++;
        if (obs.size() != exp_q.size()) begin errors++; $display("FAIL hstep count: got %0d want %0d", obs.size(), exp_q.size()); end
        foreach (obs[i]) begin
            if (i >= exp_q.size()) break;
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL hstep out%0d: got cyc=%0d x=%0d y=%0d e=%0b k=%h mag=%0d want cyc=%0d x=%0d y=%0d e=%0b k=%h mag=%0d",
                    i, obs[i].cyc, obs[i].x, obs[i].y, obs[i].e, obs[i].k, obs[i].mag,
                    exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].e, exp_q[i].k, exp_q[i].mag);
                break;
            end
        end
        na = 0; nb = 0; no = 0;
        foreach (obs[i]) begin
            if (obs[i].e) begin
                if (obs[i].y == 11'(YS + H / 2 - 1)) na++;
                else if (obs[i].y == 11'(YS + H / 2)) nb++;
                else no++;
            end
        end
        checks++;
        if (na != W - 2 || nb != W - 2 || no != 0)
            begin errors++; $display("FAIL hstep edges: got %0d/%0d/%0d want %0d/%0d/0", na, nb, no, W - 2, W - 2); end
    endtask

    task automatic test_gaps();
        int kd [2] = '{1, 3};
        int md [2] = '{0, 2};
        for (int k = 0; k < 2; k++) begin
            int ne;
            obs.delete(); exp_q.delete();
            run_frame(kd[k], md[k], 500, 30, 0, N - 1);
            flush();
            checks++;
            if (obs.size() != exp_q.size()) begin errors++; $display("FAIL gaps%0d count: got %0d want %0d", k, obs.size(), exp_q.size()); end
            foreach (obs[i]) begin
                if (i >= exp_q.size()) break;
                checks++;
                if (obs[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL gaps%0d out%0d: got cyc=%0d x=%0d y=%0d e=%0b k=%h mag=%0d want cyc=%0d x=%0d y=%0d e=%0b k=%h mag=%0d",
                        k, i, obs[i].cyc, obs[i].x, obs[i].y, obs[i].e, obs[i].k, obs[i].mag,
                        exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].e, exp_q[i].k, exp_q[i].mag);
                    break;
                end
            end
            if (k == 0) begin
                ne = 0;
                foreach (obs[i]) if (obs[i].e) ne++;
                checks++;
                if (ne != 2 * (H - 2)) begin errors++; $display("FAIL gaps edges: got %0d want %0d", ne, 2 * (H - 2)); end
            end
        end
    endtask

    task automatic test_back_to_back();
        obs.delete(); exp_q.delete();
        run_frame(3, 2, 0, 0, 0, idx(4, 7));
        run_frame(3, 2, 0, 0, 0, N - 1);
        run_frame(3, 2, 0, 0, 0, N - 1);
        flush();
        checks++;
        if (obs.size() != exp_q.size()) begin errors++; $display("FAIL b2b count: got %0d want %0d", obs.size(), exp_q.size()); end
        foreach (obs[i]) begin
            if (i >= exp_q.size()) break;
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b out%0d: got cyc=%0d x=%0d y=%0d e=%0b k=%h mag=%0d want cyc=%0d x=%0d y=%0d e=%0b k=%h mag=%0d",
                    i, obs[i].cyc, obs[i].x, obs[i].y, obs[i].e, obs[i].k, obs[i].mag,
                    exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].e, exp_q[i].k, exp_q[i].mag);
                break;
            end
        end
    endtask

    task automatic test_rst_midframe();
        int c;
        obs.delete(); exp_q.delete();
        run_frame(1, 0, 500, 0, 0, idx(H / 2, 5));
        @(negedge clk);
        pix_valid = 1'b0;
        c = cyc;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || k_sobel_out !== BG)
            begin errors++; $display("FAIL rst_async: got valid=%b k=%h want 0 %h", out_valid, k_sobel_out, BG); end
        active = 1'b0;
        while (exp_q.size() > 0 && int'(exp_q[$].cyc) > c) void'(exp_q.pop_back());
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        run_frame(1, 0, 500, 0, idx(H / 2, 5) + 1, N - 1);
        run_frame(3, 2, 0, 0, 0, N - 1);
        flush();
        checks++;
        if (obs.size() != exp_q.size()) begin errors++; $display("FAIL rst_mid count: got %0d want %0d", obs.size(), exp_q.size()); end
        foreach (obs[i]) begin
            if (i >= exp_q.size()) break;
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rst_mid out%0d: got cyc=%0d x=%0d y=%0d e=%0b k=%h mag=%0d want cyc=%0d x=%0d y=%0d e=%0b k=%h mag=%0d",
                    i, obs[i].cyc, obs[i].x, obs[i].y, obs[i].e, obs[i].k, obs[i].mag,
                    exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].e, exp_q[i].k, exp_q[i].mag);
                break;
            end
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_vstep();
        test_hstep();
        test_gaps();
        test_back_to_back();
        test_rst_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
